// File: rtl/instruction_fetch_sequencer_if.sv
// Handshake/bus bundle between the fetch sequencer, the data bus and the execution sequencer.
// master drives fetch stimulus and consumes the instruction; slave is the sequencer itself.
interface instruction_fetch_sequencer_if;
  logic       rdy;
  logic [7:0] db_in;
  logic       exec_done;
  logic       int_pending;
  logic       i_pc;
  logic       pcl_adl;
  logic       pch_adh;
  logic       sync;
  logic [7:0] opcode;
  logic [7:0] operand_lo;
  logic [7:0] operand_hi;
  logic [1:0] instr_len;
  logic       instr_valid;
  logic       int_ack;

  modport master (
    output rdy, db_in, exec_done, int_pending,
    input  i_pc, pcl_adl, pch_adh, sync, opcode, operand_lo, operand_hi,
           instr_len, instr_valid, int_ack
  );

  modport slave (
    input  rdy, db_in, exec_done, int_pending,
    output i_pc, pcl_adl, pch_adh, sync, opcode, operand_lo, operand_hi,
           instr_len, instr_valid, int_ack
  );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Fetch-side sequencer: steps the PC, latches opcode plus up to two operands,
// hands the instruction to execution and injects BRK on a pending interrupt.
//
// state    | meaning
// FETCH_OP | opcode fetch cycle (sync=1), interrupt sampled here
// OPR1     | first operand byte fetch
// OPR2     | second operand byte fetch
// EXEC     | instruction presented, waiting for exec_done
module instruction_fetch_sequencer #(
  parameter logic [7:0] BRK_OPCODE    = 8'h00,
  parameter logic [7:0] RESET_OPCODE  = 8'hEA,
  parameter bit         INT_INJECT_EN = 1'b1
) (
  input logic                          phi_2,
  input logic                          reset,
  instruction_fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {FETCH_OP, OPR1, OPR2, EXEC} state_t;

  state_t     state;
  logic [7:0] opcode_q;
  logic [7:0] operand_lo_q;
  logic [7:0] operand_hi_q;
  logic [1:0] instr_len_q;
  logic       int_ack_q;
  logic       inject;
  logic [1:0] fetched_len;

  function automatic logic [1:0] decode_len(input logic [7:0] b);
    logic [1:0] cc;
    logic [2:0] bbb;
    cc  = b[1:0];
    bbb = b[4:2];
    // 3-byte rule is checked first so it wins over the 1-byte rule
    if (bbb == 3'b011 || bbb == 3'b111 || (cc == 2'b01 && bbb == 3'b110) || b == 8'h20)
      return 2'd3;
    else if ((cc != 2'b01 && (bbb == 3'b010 || bbb == 3'b110)) || b == 8'h40 || b == 8'h60)
      return 2'd1;
    else
      return 2'd2;
  endfunction

  assign inject      = bus.int_pending && INT_INJECT_EN;
  assign fetched_len = decode_len(bus.db_in);

  always_ff @(posedge phi_2 or posedge reset) begin
    if (reset) begin
      state        <= FETCH_OP;
      opcode_q     <= RESET_OPCODE;
      operand_lo_q <= 8'h00;
      operand_hi_q <= 8'h00;
      instr_len_q  <= 2'd1;
      int_ack_q    <= 1'b0;
    end else if (bus.rdy) begin
      int_ack_q <= 1'b0;
      case (state)
        FETCH_OP: begin
          if (inject) begin
            opcode_q    <= BRK_OPCODE;
            instr_len_q <= 2'd1;
            int_ack_q   <= 1'b1;
            state       <= EXEC;
          end else begin
            opcode_q    <= bus.db_in;
            instr_len_q <= fetched_len;
            state       <= (fetched_len == 2'd1) ? EXEC : OPR1;
          end
        end
        OPR1: begin
          operand_lo_q <= bus.db_in;
          state        <= (instr_len_q == 2'd3) ? OPR2 : EXEC;
        end
        OPR2: begin
          operand_hi_q <= bus.db_in;
          state        <= EXEC;
        end
        EXEC: begin
          if (bus.exec_done) state <= FETCH_OP;
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

  // Bus drive drops with rdy; sync and instr_valid follow the state alone
  assign bus.sync        = (state == FETCH_OP);
  assign bus.pcl_adl     = bus.rdy && (state != EXEC);
  assign bus.pch_adh     = bus.rdy && (state != EXEC);
  assign bus.i_pc        = bus.rdy && (state != EXEC) && !(state == FETCH_OP && inject);
  assign bus.instr_valid = (state == EXEC);
  assign bus.opcode      = opcode_q;
  assign bus.operand_lo  = operand_lo_q;
  assign bus.operand_hi  = operand_hi_q;
  assign bus.instr_len   = instr_len_q;
  assign bus.int_ack     = int_ack_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer: vector table, reset corner and opcode length sweep.
module tb_instruction_fetch_sequencer;
  logic phi_2 = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  instruction_fetch_sequencer_if bus();

  instruction_fetch_sequencer dut (
    .phi_2 (phi_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 phi_2 = ~phi_2;

  typedef struct {
    logic       rdy;
    logic [7:0] db;
    logic       ed;
    logic       ip;
    logic       e_ipc;
    logic       e_pcl;
    logic       e_sync;
    logic       e_valid;
    logic [7:0] e_op;
    logic [7:0] e_lo;
    logic [7:0] e_hi;
    logic [1:0] e_len;
    logic       e_ack;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic rdy, logic [7:0] db, logic ed, logic ip,
                              logic ipc, logic pcl, logic sy, logic vl,
                              logic [7:0] op, logic [7:0] lo, logic [7:0] hi,
                              logic [1:0] len, logic ack);
    vec_t v;
    v.rdy = rdy; v.db = db; v.ed = ed; v.ip = ip;
    v.e_ipc = ipc; v.e_pcl = pcl; v.e_sync = sy; v.e_valid = vl;
    v.e_op = op; v.e_lo = lo; v.e_hi = hi; v.e_len = len; v.e_ack = ack;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Reference length table written from the opcode-field rules
  function automatic logic [1:0] ref_len(input logic [7:0] b);
    logic three, one;
    three = (b[4:2] == 3'd3) || (b[4:2] == 3'd7) || (b[1:0] == 2'd1 && b[4:2] == 3'd6) || (b == 8'h20);
    one   = ((b[1:0] != 2'd1) && (b[4:2] == 3'd2 || b[4:2] == 3'd6)) || (b == 8'h40) || (b == 8'h60);
    if (three) return 2'd3;
    if (one)   return 2'd1;
    return 2'd2;
  endfunction

  task automatic edge_step();
    @(posedge phi_2);
    #1;
  endtask

  initial begin
    //                rdy db     ed ip  ipc pcl sy vl  op     lo     hi     len ack
    vecs[0]  = mk(1, 8'hAD, 0, 0,  1, 1, 1, 0, 8'hAD, 8'h00, 8'h00, 3, 0);
    vecs[1]  = mk(1, 8'h34, 0, 0,  1, 1, 0, 0, 8'hAD, 8'h34, 8'h00, 3, 0);
    vecs[2]  = mk(1, 8'h12, 0, 0,  1, 1, 0, 0, 8'hAD, 8'h34, 8'h12, 3, 0);
    vecs[3]  = mk(1, 8'hFF, 0, 0,  0, 0, 0, 1, 8'hAD, 8'h34, 8'h12, 3, 0);
    vecs[4]  = mk(1, 8'hFF, 1, 0,  0, 0, 0, 1, 8'hAD, 8'h34, 8'h12, 3, 0);
    vecs[5]  = mk(1, 8'hE8, 0, 0,  1, 1, 1, 0, 8'hE8, 8'h34, 8'h12, 1, 0);
    vecs[6]  = mk(1, 8'h00, 1, 0,  0, 0, 0, 1, 8'hE8, 8'h34, 8'h12, 1, 0);
    vecs[7]  = mk(1, 8'hA9, 0, 0,  1, 1, 1, 0, 8'hA9, 8'h34, 8'h12, 2, 0);
    vecs[8]  = mk(1, 8'h05, 0, 0,  1, 1, 0, 0, 8'hA9, 8'h05, 8'h12, 2, 0);
    vecs[9]  = mk(1, 8'h00, 1, 0,  0, 0, 0, 1, 8'hA9, 8'h05, 8'h12, 2, 0);
    vecs[10] = mk(1, 8'hA9, 0, 1,  0, 1, 1, 0, 8'h00, 8'h05, 8'h12, 1, 1);
    vecs[11] = mk(1, 8'h00, 1, 0,  0, 0, 0, 1, 8'h00, 8'h05, 8'h12, 1, 0);
    vecs[12] = mk(1, 8'h99, 0, 0,  1, 1, 1, 0, 8'h99, 8'h05, 8'h12, 3, 0);
    vecs[13] = mk(0, 8'h77, 0, 0,  0, 0, 0, 0, 8'h99, 8'h05, 8'h12, 3, 0);
    vecs[14] = mk(0, 8'h77, 0, 1,  0, 0, 0, 0, 8'h99, 8'h05, 8'h12, 3, 0);
    vecs[15] = mk(0, 8'h77, 1, 1,  0, 0, 0, 0, 8'h99, 8'h05, 8'h12, 3, 0);
    vecs[16] = mk(1, 8'h11, 0, 1,  1, 1, 0, 0, 8'h99, 8'h11, 8'h12, 3, 0);
    vecs[17] = mk(1, 8'h22, 0, 1,  1, 1, 0, 0, 8'h99, 8'h11, 8'h22, 3, 0);
    vecs[18] = mk(0, 8'h00, 1, 1,  0, 0, 0, 1, 8'h99, 8'h11, 8'h22, 3, 0);
    vecs[19] = mk(1, 8'h00, 1, 1,  0, 0, 0, 1, 8'h99, 8'h11, 8'h22, 3, 0);
    vecs[20] = mk(1, 8'h20, 0, 1,  0, 1, 1, 0, 8'h00, 8'h11, 8'h22, 1, 1);
    vecs[21] = mk(1, 8'h00, 1, 0,  0, 0, 0, 1, 8'h00, 8'h11, 8'h22, 1, 0);
    vecs[22] = mk(0, 8'h60, 0, 0,  0, 0, 1, 0, 8'h00, 8'h11, 8'h22, 1, 0);
    vecs[23] = mk(1, 8'h60, 0, 0,  1, 1, 1, 0, 8'h60, 8'h11, 8'h22, 1, 0);

    bus.rdy = 1'b0; bus.db_in = 8'h00; bus.exec_done = 1'b0; bus.int_pending = 1'b0;
    #12;
    chk("rst_opcode", bus.opcode, 8'hEA);
    chk("rst_lo", bus.operand_lo, 8'h00);
    chk("rst_hi", bus.operand_hi, 8'h00);
    chk("rst_len", bus.instr_len, 2'd1);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_ack", bus.int_ack, 1'b0);
    chk("rst_sync", bus.sync, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      bus.rdy = vecs[i].rdy; bus.db_in = vecs[i].db;
      bus.exec_done = vecs[i].ed; bus.int_pending = vecs[i].ip;
      #1;
      chk($sformatf("v%0d_i_pc", i), bus.i_pc, vecs[i].e_ipc);
      chk($sformatf("v%0d_pcl_adl", i), bus.pcl_adl, vecs[i].e_pcl);
      chk($sformatf("v%0d_pch_adh", i), bus.pch_adh, vecs[i].e_pcl);
      chk($sformatf("v%0d_sync", i), bus.sync, vecs[i].e_sync);
      chk($sformatf("v%0d_valid", i), bus.instr_valid, vecs[i].e_valid);
      edge_step();
      chk($sformatf("v%0d_opcode", i), bus.opcode, vecs[i].e_op);
      chk($sformatf("v%0d_lo", i), bus.operand_lo, vecs[i].e_lo);
      chk($sformatf("v%0d_hi", i), bus.operand_hi, vecs[i].e_hi);
      chk($sformatf("v%0d_len", i), bus.instr_len, vecs[i].e_len);
      chk($sformatf("v%0d_ack", i), bus.int_ack, vecs[i].e_ack);
    end

    // Async reset landing in the middle of OPR2
    bus.rdy = 1'b1; bus.int_pending = 1'b0; bus.exec_done = 1'b1; bus.db_in = 8'h00;
    edge_step();
    bus.exec_done = 1'b0; bus.db_in = 8'hAD;
    edge_step();
    bus.db_in = 8'h34;
    edge_step();
    chk("pre_rst_len", bus.instr_len, 2'd3);
    chk("pre_rst_sync", bus.sync, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_opcode", bus.opcode, 8'hEA);
    chk("mid_rst_valid", bus.instr_valid, 1'b0);
    chk("mid_rst_sync", bus.sync, 1'b1);
    chk("mid_rst_lo", bus.operand_lo, 8'h00);
    chk("mid_rst_len", bus.instr_len, 2'd1);
    reset = 1'b0;
    #1;
    chk("post_rst_i_pc", bus.i_pc, 1'b1);

    // Length sweep across every opcode, returning to FETCH_OP within a bounded number of edges
    for (int b = 0; b < 256; b++) begin
      bus.rdy = 1'b1; bus.int_pending = 1'b0; bus.exec_done = 1'b1;
      bus.db_in = 8'(b);
      edge_step();
      chk($sformatf("len_%02h", b), bus.instr_len, ref_len(8'(b)));
      bus.db_in = 8'h00;
      for (int n = 0; n < 4 && !bus.sync; n++) edge_step();
      if (!bus.sync) begin
        chk($sformatf("return_sync_%02h", b), bus.sync, 1'b1);
        break;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
